mc_seq_ctrl: RTL and testbench
==============================

// Module: mc_seq_ctrl
// PURPOSE
//  Parametrised multi-cycle sequencer for the LA32R core: owns PC, IR and the IF/ID/EXE/MEM/WB FSM.
//  Successor to the fixed 1-cycle-SRAM sequencer: fetch and data access use req/gnt/rvalid handshakes with wait states.
//  Adds a per-access watchdog and a bounded instruction-retire counter.
//  Decoder, ALU and regfile stay outside; this block only issues strobes (ir_we, rf_we, mem req) and next-PC.
// PARAMETERS
//  RESET_PC   32'h1c000000  first fetch address after reset
//  WDOG_MAX   255           wait cycles allowed per memory response before fault (1..65535)
//  CNT_W      32            width of retire counter
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  inst_req     out  1   fetch request, held until inst_gnt
//  inst_addr    out  32  fetch address (= pc)
//  inst_gnt     in   1   fetch request accepted this cycle
//  inst_rvalid  in   1   fetch data valid
//  inst_rdata   in   32  fetched instruction
//  dec_is_br    in   1   ID: conditional branch (beq/bne) or b (no WB)
//  dec_is_ld    in   1   ID: ld.w
//  dec_is_st    in   1   ID: st.w
//  dec_gr_we    in   1   ID: instruction writes GPR
//  br_taken     in   1   EXE-valid: redirect taken (incl. jirl/bl)
//  br_target    in   32  redirect address
//  data_req     out  1   data request, held until data_gnt
//  data_we      out  1   data request is store (valid with data_req)
//  data_gnt     in   1   data request accepted
//  data_rvalid  in   1   load data / store ack valid
//  ir           out  32  instruction register
//  pc           out  32  PC of instruction in flight
//  state        out  3   FSM state (encoding in package)
//  rf_we        out  1   regfile write strobe, 1 cycle in WB
//  fault        out  1   sticky watchdog fault
//  retire_cnt   out  CNT_W retired instructions, saturating
// BEHAVIOUR
//  Reset: state=IF_REQ, pc=RESET_PC, ir=0, all req/we/rf_we=0, fault=0, retire_cnt=0. Reset mid-access drops it; late rvalid ignored.
//  States: IF_REQ->IF_WAIT on inst_gnt; IF_WAIT->ID on inst_rvalid (ir<=inst_rdata); ID->EXE always.
//   EXE: ld/st->MEM_REQ; br (no gr_we)->IF_REQ; else->WB.
//   MEM_REQ->MEM_WAIT on data_gnt; MEM_WAIT on data_rvalid: ld->WB, st->IF_REQ.
//   WB->IF_REQ; rf_we=dec_gr_we for exactly that cycle.
//  gnt and rvalid same cycle: REQ state goes direct to next (IF_REQ->ID, MEM_REQ->WB/IF_REQ); ir captured.
//  rvalid while not in *_WAIT/*_REQ-with-gnt: ignored.
//  PC update on leaving the instruction (entering IF_REQ): pc<=br_taken?br_target:pc+4; br_taken sampled in EXE only, latched for later exit.
//  Decoder inputs sampled in EXE and latched (ld/st/gr_we) for MEM/WB decisions.
//  inst_req=1 only in IF_REQ; data_req=1 only in MEM_REQ; data_we=latched st.
//  Watchdog: 16-bit counter cleared on entry to any REQ/WAIT state, +1 per stalled cycle; reaching WDOG_MAX -> state=HALT, fault=1.
//  HALT: no requests, no rf_we, pc/ir frozen; left only by reset.
//  retire_cnt +1 on entering IF_REQ from EXE/MEM_WAIT/WB; saturates at all-ones, no wrap.
//  pc+4 wraps mod 2^32; no alignment check (br_target taken as-is).
// STRUCTURE
//  Package mc_pkg: state localparams IF_REQ=0,IF_WAIT=1,ID=2,EXE=3,MEM_REQ=4,MEM_WAIT=5,WB=6,HALT=7; RESET_PC default.
//  Sub-module mc_wdog (counter + compare, clear/enable/expire); FSM, PC/IR and retire counter inline.
// TESTING
//  add.w, gnt=rvalid=1 same cycle: IF_REQ->ID->EXE->WB->IF_REQ, rf_we 1 cycle, pc 1c000000->1c000004, retire_cnt=1.
//  Fetch gnt +3, rvalid +2: inst_req held 3 cycles, ir loads on rvalid, no rf_we before WB.
//  beq taken, br_target=1c000100: EXE->IF_REQ, no rf_we, next inst_addr=1c000100.
//  ld.w / st.w, data_rvalid after 5 cycles: ld -> WB rf_we=1; st -> IF_REQ, rf_we never 1, data_we=1 with req.
//  WDOG_MAX=4, withhold inst_rvalid: HALT after 4 stall cycles, fault=1, no further reqs; reset -> pc=RESET_PC, fault=0.
//  CNT_W=3, retire 9 instructions: retire_cnt saturates at 7.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and helpers for the multi-cycle sequencer.
package mc_pkg;

  // Sequencer states; the numeric encoding is visible on the state port.
  typedef enum logic [2:0] {
    IF_REQ   = 3'd0,
    IF_WAIT  = 3'd1,
    ID       = 3'd2,
    EXE      = 3'd3,
    MEM_REQ  = 3'd4,
    MEM_WAIT = 3'd5,
    WB       = 3'd6,
    HALT     = 3'd7
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam int unsigned WDOG_W           = 16;

  // Address of the next instruction when the current one is left.
  function automatic logic [31:0] nextPc(input logic        taken,
                                         input logic [31:0] target,
                                         input logic [31:0] pc);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/mc_wdog.sv
// Per-access watchdog: counts stalled cycles and flags the last allowed one.
module mc_wdog
  import mc_pkg::*;
#(
  parameter int unsigned WDOG_MAX = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_MAX - 1);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  // Clear between accesses, count stalls, and hold at the top rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The stall that would make the count reach WDOG_MAX is the one that faults.
  assign expire_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle LA32R sequencer: PC/IR, IF/ID/EXE/MEM/WB FSM, handshakes, watchdog, retire count.
module mc_seq_ctrl
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned WDOG_MAX = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  output logic             inst_req_o,
  output logic [31:0]      inst_addr_o,
  input  logic             inst_gnt_i,
  input  logic             inst_rvalid_i,
  input  logic [31:0]      inst_rdata_i,
  input  logic             dec_is_br_i,
  input  logic             dec_is_ld_i,
  input  logic             dec_is_st_i,
  input  logic             dec_gr_we_i,
  input  logic             br_taken_i,
  input  logic [31:0]      br_target_i,
  output logic             data_req_o,
  output logic             data_we_o,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  output logic [31:0]      ir_o,
  output logic [31:0]      pc_o,
  output logic [2:0]       state_o,
  output logic             rf_we_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  state_e             state_q;
  logic [31:0]        pc_q;
  logic [31:0]        ir_q;
  logic               inst_req_q;
  logic               data_req_q;
  logic               data_we_q;
  logic               rf_we_q;
  logic               fault_q;
  logic [CNT_W-1:0]   retire_q;
  logic               ld_q;
  logic               gr_we_q;
  logic               br_taken_q;
  logic [31:0]        br_target_q;

  logic               stall;
  logic               wdogExpire;
  logic [31:0]        pc_d;
  logic [CNT_W-1:0]   retire_d;

  // A cycle is stalled when a raised request is not granted or an awaited response is absent.
  assign stall = ((state_q == IF_REQ)   && inst_req_q && !inst_gnt_i)
              || ((state_q == IF_WAIT)  && !inst_rvalid_i)
              || ((state_q == MEM_REQ)  && data_req_q && !data_gnt_i)
              || ((state_q == MEM_WAIT) && !data_rvalid_i);

  mc_wdog #(.WDOG_MAX(WDOG_MAX)) u_wdog (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (!stall),
    .enable_i (stall),
    .expire_o (wdogExpire)
  );

  // Redirect decision is live while in EXE and taken from the latched copy afterwards.
  always_comb begin
    pc_d = (state_q == EXE) ? nextPc(br_taken_i, br_target_i, pc_q)
                            : nextPc(br_taken_q, br_target_q, pc_q);
    retire_d = (retire_q == '1) ? retire_q : retire_q + CNT_W'(1);
  end

  // Main sequencer FSM with registered strobes, PC/IR and retire count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IF_REQ;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      inst_req_q  <= 1'b0;
      data_req_q  <= 1'b0;
      data_we_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      fault_q     <= 1'b0;
      retire_q    <= '0;
      ld_q        <= 1'b0;
      gr_we_q     <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        IF_REQ: begin
          if (inst_req_q && inst_gnt_i) begin
            inst_req_q <= 1'b0;
            if (inst_rvalid_i) begin
              ir_q    <= inst_rdata_i;
              state_q <= ID;
            end else begin
              state_q <= IF_WAIT;
            end
          end else if (wdogExpire) begin
            inst_req_q <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= HALT;
          end else begin
            inst_req_q <= 1'b1;
          end
        end
        IF_WAIT: begin
          if (inst_rvalid_i) begin
            ir_q    <= inst_rdata_i;
            state_q <= ID;
          end else if (wdogExpire) begin
            fault_q <= 1'b1;
            state_q <= HALT;
          end
        end
        ID: begin
          state_q <= EXE;
        end
        EXE: begin
          ld_q        <= dec_is_ld_i;
          gr_we_q     <= dec_gr_we_i;
          br_taken_q  <= br_taken_i;
          br_target_q <= br_target_i;
          if (dec_is_ld_i || dec_is_st_i) begin
            data_req_q <= 1'b1;
            data_we_q  <= dec_is_st_i;
            state_q    <= MEM_REQ;
          end else if (dec_is_br_i && !dec_gr_we_i) begin
            pc_q       <= pc_d;
            retire_q   <= retire_d;
            inst_req_q <= 1'b1;
            state_q    <= IF_REQ;
          end else begin
            rf_we_q <= dec_gr_we_i;
            state_q <= WB;
          end
        end
        MEM_REQ, MEM_WAIT: begin
          if (((state_q == MEM_REQ) && data_req_q && data_gnt_i && data_rvalid_i) ||
              ((state_q == MEM_WAIT) && data_rvalid_i)) begin
            data_req_q <= 1'b0;
            data_we_q  <= 1'b0;
            if (ld_q) begin
              rf_we_q <= gr_we_q;
              state_q <= WB;
            end else begin
              pc_q       <= pc_d;
              retire_q   <= retire_d;
              inst_req_q <= 1'b1;
              state_q    <= IF_REQ;
            end
          end else if ((state_q == MEM_REQ) && data_req_q && data_gnt_i) begin
            data_req_q <= 1'b0;
            state_q    <= MEM_WAIT;
          end else if (wdogExpire) begin
            data_req_q <= 1'b0;
            data_we_q  <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= HALT;
          end
        end
        WB: begin
          pc_q       <= pc_d;
          retire_q   <= retire_d;
          inst_req_q <= 1'b1;
          state_q    <= IF_REQ;
        end
        default: begin
          state_q <= HALT;
        end
      endcase
    end
  end

  assign inst_req_o   = inst_req_q;
  assign inst_addr_o  = pc_q;
  assign data_req_o   = data_req_q;
  assign data_we_o    = data_we_q;
  assign ir_o         = ir_q;
  assign pc_o         = pc_q;
  assign state_o      = state_q;
  assign rf_we_o      = rf_we_q;
  assign fault_o      = fault_q;
  assign retire_cnt_o = retire_q;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed self-checking bench for mc_seq_ctrl: default instance plus a small-watchdog/3-bit-counter instance.
module tb_mc_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h1c000000;
  localparam logic [31:0] ADD_W  = 32'h00101c84;
  localparam logic [31:0] SUB_W  = 32'h00111cc5;
  localparam logic [31:0] BEQ_I  = 32'h58004086;
  localparam logic [31:0] LD_W   = 32'h28800087;
  localparam logic [31:0] ST_W   = 32'h29800088;

  logic        clk = 1'b0;
  logic        reset;
  logic        instGnt, instRvalid;
  logic [31:0] instRdata;
  logic        decIsBr, decIsLd, decIsSt, decGrWe, brTaken;
  logic [31:0] brTarget;
  logic        dataGnt, dataRvalid;

  logic        aInstReq, aDataReq, aDataWe, aRfWe, aFault;
  logic [31:0] aInstAddr, aIr, aPc, aRetire;
  logic [2:0]  aState;

  logic        bInstReq, bDataReq, bDataWe, bRfWe, bFault;
  logic [31:0] bInstAddr, bIr, bPc;
  logic [2:0]  bState, bRetire;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  mc_seq_ctrl dutA (
    .clk_i(clk), .reset_i(reset),
    .inst_req_o(aInstReq), .inst_addr_o(aInstAddr), .inst_gnt_i(instGnt),
    .inst_rvalid_i(instRvalid), .inst_rdata_i(instRdata),
    .dec_is_br_i(decIsBr), .dec_is_ld_i(decIsLd), .dec_is_st_i(decIsSt),
    .dec_gr_we_i(decGrWe), .br_taken_i(brTaken), .br_target_i(brTarget),
    .data_req_o(aDataReq), .data_we_o(aDataWe), .data_gnt_i(dataGnt),
    .data_rvalid_i(dataRvalid), .ir_o(aIr), .pc_o(aPc), .state_o(aState),
    .rf_we_o(aRfWe), .fault_o(aFault), .retire_cnt_o(aRetire)
  );

  mc_seq_ctrl #(.WDOG_MAX(4), .CNT_W(3)) dutB (
    .clk_i(clk), .reset_i(reset),
    .inst_req_o(bInstReq), .inst_addr_o(bInstAddr), .inst_gnt_i(instGnt),
    .inst_rvalid_i(instRvalid), .inst_rdata_i(instRdata),
    .dec_is_br_i(decIsBr), .dec_is_ld_i(decIsLd), .dec_is_st_i(decIsSt),
    .dec_gr_we_i(decGrWe), .br_taken_i(brTaken), .br_target_i(brTarget),
    .data_req_o(bDataReq), .data_we_o(bDataWe), .data_gnt_i(dataGnt),
    .data_rvalid_i(dataRvalid), .ir_o(bIr), .pc_o(bPc), .state_o(bState),
    .rf_we_o(bRfWe), .fault_o(bFault), .retire_cnt_o(bRetire)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    instGnt    = gnt;
    instRvalid = rvalid;
    instRdata  = rdata;
  endtask

  task automatic setDecode(input logic br, input logic ld, input logic st, input logic grWe,
                           input logic taken, input logic [31:0] target);
    decIsBr  = br;
    decIsLd  = ld;
    decIsSt  = st;
    decGrWe  = grWe;
    brTaken  = taken;
    brTarget = target;
  endtask

  task automatic assertReset();
    reset      = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    setDecode(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    dataGnt    = 1'b0;
    dataRvalid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic releaseReset();
    reset = 1'b0;
    tick();
  endtask

  // One add.w with same-cycle grant and data, waiting (bounded) for the fetch request first.
  task automatic runAdd();
    int waited = 0;
    while (!aInstReq && waited < 20) begin
      tick();
      waited++;
    end
    if (!aInstReq) checkOutput("add_req_timeout", 32'(aInstReq), 32'd1);
    setDecode(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, ADD_W);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (3) tick();
  endtask

  initial begin
    // Reset values
    assertReset();
    checkOutput("rst_state", 32'(aState), 32'd0);
    checkOutput("rst_pc", aPc, RST_PC);
    checkOutput("rst_ir", aIr, 32'h0);
    checkOutput("rst_inst_req", 32'(aInstReq), 32'd0);
    checkOutput("rst_data_req", 32'(aDataReq), 32'd0);
    checkOutput("rst_rf_we", 32'(aRfWe), 32'd0);
    checkOutput("rst_fault", 32'(aFault), 32'd0);
    checkOutput("rst_retire", aRetire, 32'd0);
    releaseReset();
    checkOutput("fetch_req_up", 32'(aInstReq), 32'd1);

    // add.w with gnt and rvalid in the same cycle
    setDecode(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, ADD_W);
    tick();
    checkOutput("add_state_id", 32'(aState), 32'd2);
    checkOutput("add_ir", aIr, ADD_W);
    checkOutput("add_req_drop", 32'(aInstReq), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("add_state_exe", 32'(aState), 32'd3);
    checkOutput("add_no_rf_we_exe", 32'(aRfWe), 32'd0);
    tick();
    checkOutput("add_state_wb", 32'(aState), 32'd6);
    checkOutput("add_rf_we_wb", 32'(aRfWe), 32'd1);
    tick();
    checkOutput("add_state_ifreq", 32'(aState), 32'd0);
    checkOutput("add_rf_we_off", 32'(aRfWe), 32'd0);
    checkOutput("add_pc", aPc, 32'h1c000004);
    checkOutput("add_inst_addr", aInstAddr, 32'h1c000004);
    checkOutput("add_retire", aRetire, 32'd1);

    // Fetch with grant after 3 cycles and data 2 cycles later
    for (int i = 0; i < 2; i++) begin
      checkOutput("wait_req_held", 32'(aInstReq), 32'd1);
      tick();
    end
    checkOutput("wait_req_held3", 32'(aInstReq), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("wait_state_ifwait", 32'(aState), 32'd1);
    checkOutput("wait_req_drop", 32'(aInstReq), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("wait_ir_old", aIr, ADD_W);
    applyStimulus(1'b0, 1'b1, SUB_W);
    tick();
    checkOutput("wait_state_id", 32'(aState), 32'd2);
    checkOutput("wait_ir_new", aIr, SUB_W);
    checkOutput("wait_no_rf_we", 32'(aRfWe), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("wait_no_rf_we_exe", 32'(aRfWe), 32'd0);
    tick();
    checkOutput("wait_rf_we_wb", 32'(aRfWe), 32'd1);
    tick();
    checkOutput("wait_pc", aPc, 32'h1c000008);

    // Taken beq
    applyStimulus(1'b1, 1'b1, BEQ_I);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    setDecode(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1c000100);
    tick();
    checkOutput("beq_state_exe", 32'(aState), 32'd3);
    tick();
    checkOutput("beq_state_ifreq", 32'(aState), 32'd0);
    checkOutput("beq_no_rf_we", 32'(aRfWe), 32'd0);
    checkOutput("beq_inst_addr", aInstAddr, 32'h1c000100);
    checkOutput("beq_retire", aRetire, 32'd3);

    // ld.w, data response 5 cycles after grant
    setDecode(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, LD_W);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    setDecode(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("ld_state_memreq", 32'(aState), 32'd4);
    checkOutput("ld_data_req", 32'(aDataReq), 32'd1);
    checkOutput("ld_data_we", 32'(aDataWe), 32'd0);
    setDecode(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    dataGnt = 1'b1;
    tick();
    dataGnt = 1'b0;
    checkOutput("ld_state_memwait", 32'(aState), 32'd5);
    checkOutput("ld_data_req_drop", 32'(aDataReq), 32'd0);
    repeat (4) tick();
    checkOutput("ld_still_wait", 32'(aState), 32'd5);
    dataRvalid = 1'b1;
    tick();
    dataRvalid = 1'b0;
    checkOutput("ld_state_wb", 32'(aState), 32'd6);
    checkOutput("ld_rf_we", 32'(aRfWe), 32'd1);
    tick();
    checkOutput("ld_pc", aPc, 32'h1c000104);
    checkOutput("ld_retire", aRetire, 32'd4);

    // st.w, data response 5 cycles after grant
    applyStimulus(1'b1, 1'b1, ST_W);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    setDecode(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("st_no_rf_we_exe", 32'(aRfWe), 32'd0);
    tick();
    checkOutput("st_data_req", 32'(aDataReq), 32'd1);
    checkOutput("st_data_we", 32'(aDataWe), 32'd1);
    checkOutput("st_no_rf_we_req", 32'(aRfWe), 32'd0);
    setDecode(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    dataGnt = 1'b1;
    tick();
    dataGnt = 1'b0;
    repeat (4) tick();
    checkOutput("st_no_rf_we_wait", 32'(aRfWe), 32'd0);
    dataRvalid = 1'b1;
    tick();
    dataRvalid = 1'b0;
    checkOutput("st_state_ifreq", 32'(aState), 32'd0);
    checkOutput("st_no_rf_we_end", 32'(aRfWe), 32'd0);
    checkOutput("st_data_we_off", 32'(aDataWe), 32'd0);
    checkOutput("st_pc", aPc, 32'h1c000108);
    checkOutput("st_retire", aRetire, 32'd5);

    // Watchdog on the WDOG_MAX=4 instance: grant fetch, withhold data
    assertReset();
    releaseReset();
    checkOutput("wd_req", 32'(bInstReq), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wd_state_ifwait", 32'(bState), 32'd1);
    repeat (3) tick();
    checkOutput("wd_not_yet", 32'(bState), 32'd1);
    checkOutput("wd_no_fault_yet", 32'(bFault), 32'd0);
    tick();
    checkOutput("wd_state_halt", 32'(bState), 32'd7);
    checkOutput("wd_fault", 32'(bFault), 32'd1);
    applyStimulus(1'b1, 1'b1, SUB_W);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wd_halt_stays", 32'(bState), 32'd7);
    checkOutput("wd_no_inst_req", 32'(bInstReq), 32'd0);
    checkOutput("wd_no_data_req", 32'(bDataReq), 32'd0);
    checkOutput("wd_ir_frozen", bIr, 32'h0);
    checkOutput("wd_pc_frozen", bPc, RST_PC);
    assertReset();
    checkOutput("wd_rst_fault", 32'(bFault), 32'd0);
    checkOutput("wd_rst_pc", bPc, RST_PC);
    checkOutput("wd_rst_state", 32'(bState), 32'd0);
    releaseReset();

    // Retire counter saturation on the 3-bit instance
    for (int i = 0; i < 7; i++) runAdd();
    checkOutput("sat_retire7", 32'(bRetire), 32'd7);
    for (int i = 0; i < 2; i++) runAdd();
    checkOutput("sat_retire9", 32'(bRetire), 32'd7);
    checkOutput("sat_wide_retire9", aRetire, 32'd9);
    checkOutput("sat_pc", bPc, 32'h1c000024);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
